mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters (name, default, meaning):
- UART_ADDR, 32'h0000_fff0, UART transmit MMIO byte.
- UART_FLAG_ADDR, 32'h0000_fff1, UART ready-flag MMIO byte.
- COUNTER_ADDR, 32'h0000_fff4, cycle-counter MMIO word.
REQ-002 Ports (name, direction, width, meaning):
- clock, in, 1, sole clock; all state updates on its rising edge.
- reset, in, 1, synchronous, active-high.
- if_req, in, 1, fetch request; held until if_gnt.
- if_addr, in, 32, fetch byte address.
- if_gnt, out, 1, fetch accepted (1-cycle pulse).
- if_rvalid, out, 1, fetch data valid (1-cycle pulse).
- if_rdata, out, 32, fetched word.
- if_err, out, 1, misaligned fetch; qualified by if_rvalid.
- d_req, in, 1, data request; held until d_gnt.
- d_we, in, 1, 1 = store.
- d_size, in, 3, RV funct3: LB/LH/LW/LBU/LHU, SB/SH/SW.
- d_addr, in, 32, data byte address.
- d_wdata, in, 32, store data, low-aligned.
- d_gnt, out, 1, data request accepted.
- d_rvalid, out, 1, data response (loads and stores).
- d_rdata, out, 32, extended load data; 0 on stores.
- d_err, out, 1, misaligned or illegal d_size; qualified by d_rvalid.
- m_req, out, 1, memory request.
- m_we, out, 1, memory write.
- m_addr, out, 32, word-aligned address.
- m_be, out, 4, byte enables.
- m_wdata, out, 32, lane-shifted store data.
- m_ack, in, 1, memory done; m_rdata valid this cycle.
- m_rdata, in, 32, memory read word.
- uart_out, out, 9, {strobe, byte}; strobe pulses 1 cycle per UART store.

Function
REQ-003 States: IDLE, MEM (waiting m_ack), RESP (MMIO/error response).
REQ-004 Acceptance only in IDLE: d_req wins over if_req when both are asserted; the loser gets no gnt and keeps its req asserted.
REQ-005 Gnt is a combinational pulse in the accepting IDLE cycle; address, size, we and wdata are captured that cycle.
REQ-006 Misaligned access (LH/LHU/SH addr[0]=1; LW/SW/fetch addr[1:0]≠0) or illegal d_size → RESP; err=1, rdata=0, no m_req, no uart strobe.
REQ-007 Data access whose word address equals UART_ADDR, UART_FLAG_ADDR or COUNTER_ADDR (bits [31:2] compare) → RESP, no m_req.
- SB/SH/SW to UART_ADDR: uart_out={1,d_wdata[7:0]} in the RESP cycle.
- LB/LBU of UART_FLAG_ADDR: returns 1.
- LW of COUNTER_ADDR: returns counter.
- Any other MMIO access: returns 0, no side effect, err=0.
REQ-008 Otherwise → MEM. m_req=1 from the cycle after gnt through the m_ack cycle inclusive; m_addr/m_we/m_be/m_wdata stay stable throughout.
REQ-009 m_be: byte = 1<<addr[1:0]; half = 3<<addr[1:0]; word = 4'hf. m_wdata replicates the byte/half into every lane.
REQ-010 m_ack in MEM → IDLE; rvalid is registered and pulses the cycle after m_ack. The next gnt is possible in that same cycle.
REQ-011 Load extraction from m_rdata uses addr[1:0]: LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through. if_rdata = m_rdata.
REQ-012 RESP lasts exactly 1 cycle; rvalid pulses in that cycle; then IDLE.
REQ-013 Response throughput: at most one rvalid per 2 cycles. if_rvalid and d_rvalid are never high together.
REQ-014 m_ack outside MEM is ignored.
REQ-015 counter is 32 bits, +1 every cycle, wraps 32'hffff_ffff→0.

Reset
REQ-016 While reset=1 at a clock edge: state=IDLE, counter=0. These outputs are 0: m_req, m_we, m_be, m_addr, m_wdata, if_rvalid, d_rvalid, if_err, d_err, if_rdata, d_rdata, uart_out.
REQ-017 While reset=1, if_gnt=0 and d_gnt=0 (combinational).
REQ-018 Reset in MEM/RESP abandons the transaction: no rvalid, m_req=0 from the next cycle, a later m_ack is ignored.

Structure
REQ-019 Shared package holds: the funct3 load/store size constants, the state enum, and the MMIO address defaults.
REQ-020 One sub-module, mem_lane_align: combinational byte-enable/wdata shift and load extract/extend; instantiated once.

Verification
REQ-021 Directed scenarios:
- Contention: if_req and d_req both 1 in IDLE, LW addr 0x100, m_ack 2 cycles after m_req rises → d_gnt first. m_addr=0x100, m_be=f, d_rvalid on the cycle after m_ack. if_gnt comes in that same cycle.
- Load extraction: LB addr 0x203, m_rdata 0x80_00_00_00 → d_rdata=0xffff_ff80. LBU with the same inputs → 0x0000_0080.
- SH addr 0x302, d_wdata 0xabcd → m_be=4'b1100, m_wdata=0xabcd_abcd, d_rvalid after m_ack.
- SB 0x41 to 0xfff0 → uart_out=0x141 for 1 cycle, no m_req. LW 0xfff4 issued 10 cycles after reset → d_rdata equals counter, not memory.
- LW addr 0x102 → d_err=1, d_rvalid the cycle after gnt, m_req never asserted.
- Reset while in MEM, then m_ack 2 cycles later → no rvalid, m_req=0, state IDLE, counter=0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data memory port arbiter:
// RV funct3 access sizes, FSM states and default MMIO addresses.
package mem_port_arbiter_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [31:0] DEF_UART_ADDR      = 32'h0000_fff0;
  localparam logic [31:0] DEF_UART_FLAG_ADDR = 32'h0000_fff1;
  localparam logic [31:0] DEF_COUNTER_ADDR   = 32'h0000_fff4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_port_arbiter_lane_align.sv
// Byte-lane steering: store byte enables / lane replication and
// load byte/half extraction with sign or zero extension.
module mem_lane_align
  import mem_port_arbiter_pkg::*;
(
  input  logic [2:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_lanes,
  input  logic [2:0]  ld_size,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [31:0] shifted_s;

  // Store side: enables follow the offset, data is replicated to every lane.
  always_comb begin
    st_be    = 4'h0;
    st_lanes = 32'h0000_0000;
    case (st_size[1:0])
      2'b00: begin
        st_be    = 4'b0001 << st_off;
        st_lanes = {4{st_wdata[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << st_off;
        st_lanes = {2{st_wdata[15:0]}};
      end
      2'b10: begin
        st_be    = 4'hf;
        st_lanes = st_wdata;
      end
      default: begin
        st_be    = 4'h0;
        st_lanes = 32'h0000_0000;
      end
    endcase
  end

  // Load side: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    shifted_s = ld_word >> {ld_off, 3'b000};
    ld_data   = 32'h0000_0000;
    case (ld_size)
      F3_LB:   ld_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
      F3_LH:   ld_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
      F3_LW:   ld_data = ld_word;
      F3_LBU:  ld_data = {24'h00_0000, shifted_s[7:0]};
      F3_LHU:  ld_data = {16'h0000, shifted_s[15:0]};
      default: ld_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one memory port, decoding
// misaligned/illegal accesses and a small MMIO block (UART, flag, counter).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter logic [31:0] UART_ADDR      = DEF_UART_ADDR,
  parameter logic [31:0] UART_FLAG_ADDR = DEF_UART_FLAG_ADDR,
  parameter logic [31:0] COUNTER_ADDR   = DEF_COUNTER_ADDR
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [3:0]  m_be,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata,
  output logic [8:0]  uart_out
);

  state_t      state_r, state_s;
  logic [31:0] counter_r;
  logic [2:0]  size_r;
  logic [1:0]  addr_lo_r;
  logic        we_r, src_d_r;
  logic        m_req_r, m_we_r;
  logic [31:0] m_addr_r, m_wdata_r;
  logic [3:0]  m_be_r;
  logic        if_rvalid_r, d_rvalid_r, if_err_r, d_err_r;
  logic [31:0] if_rdata_r, d_rdata_r;
  logic [8:0]  uart_out_r;

  logic [31:0] req_addr_s, mmio_data_s, st_lanes_s, ld_data_s;
  logic [2:0]  req_size_s;
  logic [3:0]  st_be_s;
  logic        req_we_s, misalign_s, illegal_s, err_s, mmio_s, uart_strobe_s, acc_s;

  mem_lane_align u_align (
    .st_size  (d_size),
    .st_off   (d_addr[1:0]),
    .st_wdata (d_wdata),
    .st_be    (st_be_s),
    .st_lanes (st_lanes_s),
    .ld_size  (size_r),
    .ld_off   (addr_lo_r),
    .ld_word  (m_rdata),
    .ld_data  (ld_data_s)
  );

  // Request decode: the data port has priority; fetches are always words.
  always_comb begin
    if (d_req) begin
      req_addr_s = d_addr;
      req_size_s = d_size;
      req_we_s   = d_we;
      illegal_s  = d_we ? (d_size[2] || (d_size[1:0] == 2'b11))
                        : ((d_size[1:0] == 2'b11) || (d_size[2:1] == 2'b11));
    end else begin
      req_addr_s = if_addr;
      req_size_s = F3_LW;
      req_we_s   = 1'b0;
      illegal_s  = 1'b0;
    end
    case (req_size_s[1:0])
      2'b01:   misalign_s = req_addr_s[0];
      2'b10:   misalign_s = (req_addr_s[1:0] != 2'b00);
      default: misalign_s = 1'b0;
    endcase
    err_s  = misalign_s || illegal_s;
    mmio_s = d_req && !err_s &&
             ((req_addr_s[31:2] == UART_ADDR[31:2]) ||
              (req_addr_s[31:2] == UART_FLAG_ADDR[31:2]) ||
              (req_addr_s[31:2] == COUNTER_ADDR[31:2]));
    uart_strobe_s = mmio_s && req_we_s && (req_addr_s == UART_ADDR);
    if (mmio_s && !req_we_s && (req_addr_s == UART_FLAG_ADDR) && (req_size_s[1:0] == 2'b00)) begin
      mmio_data_s = 32'h0000_0001;
    end else if (mmio_s && !req_we_s && (req_addr_s == COUNTER_ADDR) && (req_size_s == F3_LW)) begin
      mmio_data_s = counter_r;
    end else begin
      mmio_data_s = 32'h0000_0000;
    end
  end

  // Next state and combinational grants.
  always_comb begin
    state_s = state_r;
    acc_s   = 1'b0;
    if_gnt  = 1'b0;
    d_gnt   = 1'b0;
    if (!reset && (state_r == ST_IDLE) && (d_req || if_req)) begin
      acc_s  = 1'b1;
      d_gnt  = d_req;
      if_gnt = !d_req;
    end else begin
      acc_s = 1'b0;
    end
    case (state_r)
      ST_IDLE: begin
        if (acc_s) begin
          state_s = (err_s || mmio_s) ? ST_RESP : ST_MEM;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_MEM: begin
        if (m_ack) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_MEM;
        end
      end
      ST_RESP: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State, counter, captured request and all registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      counter_r   <= 32'h0000_0000;
      size_r      <= 3'b000;
      addr_lo_r   <= 2'b00;
      we_r        <= 1'b0;
      src_d_r     <= 1'b0;
      m_req_r     <= 1'b0;
      m_we_r      <= 1'b0;
      m_addr_r    <= 32'h0000_0000;
      m_be_r      <= 4'h0;
      m_wdata_r   <= 32'h0000_0000;
      if_rvalid_r <= 1'b0;
      d_rvalid_r  <= 1'b0;
      if_err_r    <= 1'b0;
      d_err_r     <= 1'b0;
      if_rdata_r  <= 32'h0000_0000;
      d_rdata_r   <= 32'h0000_0000;
      uart_out_r  <= 9'h000;
    end else begin
      state_r     <= state_s;
      counter_r   <= counter_r + 32'd1;
      if_rvalid_r <= 1'b0;
      d_rvalid_r  <= 1'b0;
      uart_out_r  <= 9'h000;
      if (acc_s) begin
        size_r    <= req_size_s;
        addr_lo_r <= req_addr_s[1:0];
        we_r      <= req_we_s;
        src_d_r   <= d_req;
        if (state_s == ST_MEM) begin
          m_req_r   <= 1'b1;
          m_we_r    <= req_we_s;
          m_addr_r  <= {req_addr_s[31:2], 2'b00};
          m_be_r    <= d_req ? st_be_s : 4'hf;
          m_wdata_r <= d_req ? st_lanes_s : 32'h0000_0000;
        end else if (d_req) begin
          d_rvalid_r <= 1'b1;
          d_err_r    <= err_s;
          d_rdata_r  <= mmio_data_s;
          uart_out_r <= uart_strobe_s ? {1'b1, d_wdata[7:0]} : 9'h000;
        end else begin
          // Only a misaligned fetch can take the short response path.
          if_rvalid_r <= 1'b1;
          if_err_r    <= 1'b1;
          if_rdata_r  <= 32'h0000_0000;
        end
      end else if ((state_r == ST_MEM) && m_ack) begin
        m_req_r <= 1'b0;
        if (src_d_r) begin
          d_rvalid_r <= 1'b1;
          d_err_r    <= 1'b0;
          d_rdata_r  <= we_r ? 32'h0000_0000 : ld_data_s;
        end else begin
          if_rvalid_r <= 1'b1;
          if_err_r    <= 1'b0;
          if_rdata_r  <= m_rdata;
        end
      end else begin
        m_req_r <= m_req_r;
      end
    end
  end

  assign m_req     = m_req_r;
  assign m_we      = m_we_r;
  assign m_addr    = m_addr_r;
  assign m_be      = m_be_r;
  assign m_wdata   = m_wdata_r;
  assign if_rvalid = if_rvalid_r;
  assign if_err    = if_err_r;
  assign if_rdata  = if_rdata_r;
  assign d_rvalid  = d_rvalid_r;
  assign d_err     = d_err_r;
  assign d_rdata   = d_rdata_r;
  assign uart_out  = uart_out_r;

endmodule
